// File: rtl/rw_release_ctrl.sv
// rw_release_ctrl: return path for the 1-clock read/write conflict solver.
// Every successful insert is queued with the timestamp of its push. The
// location is handed back to the solver as a one-cycle delete once it has
// been held for HOLD_CYCLES cycles. All entries have the same hold time, so
// the head of the FIFO is always the next entry to expire.
module rw_release_ctrl #(
    parameter int LOC_WIDTH   = 6,
    parameter int QUEUE_LEN   = 64,
    parameter int HOLD_CYCLES = 16,
    parameter int TS_WIDTH    = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 valid_in,
    input  logic                 insert_success,
    input  logic [LOC_WIDTH-1:0] insert_loc,
    input  logic                 flush,
    output logic                 valid_delete,
    output logic [LOC_WIDTH-1:0] del_loc_out,
    output logic [LOC_WIDTH:0]   pending_cnt,
    output logic                 empty,
    output logic                 overflow
);

    localparam int PTR_W = (QUEUE_LEN > 1) ? $clog2(QUEUE_LEN) : 1;
    localparam logic [PTR_W-1:0]    PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W-1:0]    PTR_LAST = PTR_W'(QUEUE_LEN - 1);
    localparam logic [LOC_WIDTH:0]  CNT_ONE  = (LOC_WIDTH + 1)'(1);
    localparam logic [LOC_WIDTH:0]  CNT_FULL = (LOC_WIDTH + 1)'(QUEUE_LEN);
    localparam logic [TS_WIDTH-1:0] TS_ONE   = TS_WIDTH'(1);
    localparam logic [TS_WIDTH-1:0] HOLD_TS  = TS_WIDTH'(HOLD_CYCLES);

    logic [LOC_WIDTH-1:0] loc_mem [QUEUE_LEN];
    logic [TS_WIDTH-1:0]  ts_mem  [QUEUE_LEN];

    logic [TS_WIDTH-1:0]  now_q;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LOC_WIDTH:0]   cnt_q, cnt_d;
    logic                 vd_q;
    logic [LOC_WIDTH-1:0] dl_q, dl_d;
    logic                 ovf_q, ovf_d;

    logic [TS_WIDTH-1:0]  age;
    logic                 is_empty;
    logic                 is_full;
    logic                 push_req;
    logic                 push;
    logic                 pop;

    // Pointers wrap explicitly so QUEUE_LEN need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_ONE;
    endfunction

    // Pop/push decision and next-state computation.
    always_comb begin
        // Modular subtraction stays correct across timestamp wrap because the
        // oldest entry can never be older than HOLD_CYCLES + QUEUE_LEN.
        age      = now_q - ts_mem[rd_ptr_q];
        is_empty = (cnt_q == '0);
        is_full  = (cnt_q == CNT_FULL);
        pop      = !is_empty && (flush || (age >= HOLD_TS));
        push_req = valid_in && insert_success;
        // A full FIFO still accepts a push when the head leaves in the same cycle.
        push     = push_req && (!is_full || pop);

        cnt_d = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + CNT_ONE;
        end else if (pop && !push) begin
            cnt_d = cnt_q - CNT_ONE;
        end

        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        dl_d     = pop  ? loc_mem[rd_ptr_q] : dl_q;
        ovf_d    = ovf_q || (push_req && !push);
    end

    // Control state: timestamp, pointers, occupancy, delete strobe, sticky overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            now_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            vd_q     <= 1'b0;
            dl_q     <= '0;
            ovf_q    <= 1'b0;
        end else begin
            now_q    <= now_q + TS_ONE;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            vd_q     <= pop;
            dl_q     <= dl_d;
            ovf_q    <= ovf_d;
        end
    end

    // Entry storage; contents are only meaningful between rd_ptr and wr_ptr.
    always_ff @(posedge clk) begin
        if (push) begin
            loc_mem[wr_ptr_q] <= insert_loc;
            ts_mem[wr_ptr_q]  <= now_q;
        end
    end

    assign valid_delete = vd_q;
    assign del_loc_out  = dl_q;
    assign pending_cnt  = cnt_q;
    assign empty        = is_empty;
    assign overflow     = ovf_q;

endmodule

// File: tb/tb_rw_release_ctrl.sv
// Bench for rw_release_ctrl: a default-size instance and a small instance
// (QUEUE_LEN=4, TS_WIDTH=5) share one stimulus stream. The reference model
// tracks each outstanding location with the absolute edge number of its push.
module tb_rw_release_ctrl;

    localparam int HOLD = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       valid_in;
    logic       insert_success;
    logic [5:0] insert_loc;
    logic       flush;

    logic       vd0, em0, ov0;
    logic [5:0] dl0;
    logic [6:0] pc0;
    logic       vd1, em1, ov1;
    logic [5:0] dl1;
    logic [6:0] pc1;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rw_release_ctrl #(.LOC_WIDTH(6), .QUEUE_LEN(64), .HOLD_CYCLES(HOLD), .TS_WIDTH(8)) u_big (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .insert_success(insert_success),
        .insert_loc(insert_loc), .flush(flush), .valid_delete(vd0), .del_loc_out(dl0),
        .pending_cnt(pc0), .empty(em0), .overflow(ov0));

    rw_release_ctrl #(.LOC_WIDTH(6), .QUEUE_LEN(4), .HOLD_CYCLES(HOLD), .TS_WIDTH(5)) u_small (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .insert_success(insert_success),
        .insert_loc(insert_loc), .flush(flush), .valid_delete(vd1), .del_loc_out(dl1),
        .pending_cnt(pc1), .empty(em1), .overflow(ov1));

    // Reference model: per instance, a list of (location, push edge number).
    int m_loc [2][64];
    int m_t   [2][64];
    int m_hd  [2];
    int m_n   [2];
    int m_ov  [2];
    int m_vd  [2];
    int m_dl  [2];
    int qlen  [2] = '{64, 4};
    int edge_no;

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s at edge %0d: got %0d, expected %0d", tag, edge_no, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_hd[i] = 0;
            m_n[i]  = 0;
            m_ov[i] = 0;
            m_vd[i] = 0;
            m_dl[i] = 0;
        end
        edge_no = 0;
    endtask

    task automatic model_edge();
        edge_no++;
        for (int i = 0; i < 2; i++) begin
            bit pop;
            pop = (m_n[i] > 0) && (flush || (edge_no - m_t[i][m_hd[i]] >= HOLD));
            m_vd[i] = pop ? 1 : 0;
            if (pop) begin
                m_dl[i] = m_loc[i][m_hd[i]];
                m_hd[i] = (m_hd[i] + 1) % 64;
                m_n[i]--;
            end
            if (valid_in && insert_success) begin
                if (m_n[i] < qlen[i]) begin
                    m_loc[i][(m_hd[i] + m_n[i]) % 64] = int'(insert_loc);
                    m_t[i][(m_hd[i] + m_n[i]) % 64]   = edge_no;
                    m_n[i]++;
                end else begin
                    m_ov[i] = 1;
                end
            end
        end
    endtask

    task automatic check_all();
        chk("big.valid_delete",   int'(vd0), m_vd[0]);
        chk("big.del_loc_out",    int'(dl0), m_dl[0]);
        chk("big.pending_cnt",    int'(pc0), m_n[0]);
        chk("big.empty",          int'(em0), (m_n[0] == 0) ? 1 : 0);
        chk("big.overflow",       int'(ov0), m_ov[0]);
        chk("small.valid_delete", int'(vd1), m_vd[1]);
        chk("small.del_loc_out",  int'(dl1), m_dl[1]);
        chk("small.pending_cnt",  int'(pc1), m_n[1]);
        chk("small.empty",        int'(em1), (m_n[1] == 0) ? 1 : 0);
        chk("small.overflow",     int'(ov1), m_ov[1]);
    endtask

    // Called at a falling edge: drive inputs, take one rising edge, check.
    task automatic step(input bit v, input bit s, input int l, input bit f);
        valid_in       = v;
        insert_success = s;
        insert_loc     = 6'(l);
        flush          = f;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 0, 1'b0);
    endtask

    task automatic rand_steps(input int n, input bit allow_flush);
        for (int k = 0; k < n; k++) begin
            step(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
                 int'($urandom_range(0, 63)),
                 allow_flush && ($urandom_range(0, 15) == 0));
        end
    endtask

    // Asynchronous reset applied mid-cycle, held for n cycles with valid_in toggling.
    task automatic do_reset(input int n);
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        for (int k = 0; k < n; k++) begin
            valid_in       = ~valid_in;
            insert_success = 1'b1;
            insert_loc     = 6'(k);
            @(negedge clk);
            check_all();
        end
        rst_n          = 1'b1;
        valid_in       = 1'b0;
        insert_success = 1'b0;
    endtask

    initial begin
        rst_n          = 1'b0;
        valid_in       = 1'b0;
        insert_success = 1'b0;
        insert_loc     = '0;
        flush          = 1'b0;
        model_reset();
        @(negedge clk);
        do_reset(5);
        idle(3);

        // Single release of loc 5, then a failed insert that must never come back.
        step(1'b1, 1'b1, 5, 1'b0);
        idle(20);
        step(1'b1, 1'b0, 9, 1'b0);
        idle(20);

        // Back-to-back pushes, with one more push landing on the first pop edge.
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, i, 1'b0);
        idle(10);
        step(1'b1, 1'b1, 40, 1'b0);
        idle(25);

        // Five consecutive pushes: the small instance drops the fifth.
        do_reset(1);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 10 + i, 1'b0);
        idle(25);

        // Fifth push coincides with the first pop: accepted, no overflow.
        do_reset(1);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 20 + i, 1'b0);
        idle(12);
        step(1'b1, 1'b1, 30, 1'b0);
        idle(25);

        // Flush with three pending, plus flush on an empty FIFO.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 50 + i, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 0, 1'b1);
        idle(3);

        // Random traffic long enough to wrap the small instance's timestamp many times.
        rand_steps(400, 1'b1);
        idle(30);

        // Reset in the middle of traffic discards everything pending.
        rand_steps(20, 1'b0);
        do_reset(2);
        idle(30);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rw_release_ctrl.md
Name: rw_release_ctrl

Overview:
- Return path for the 1-clock read/write conflict solver.
- Consumes the solver's insert result stream (valid, success, loc) and holds each successfully inserted location for a fixed number of cycles.
- When that hold expires, issues a one-cycle delete (valid_delete + location) back to the solver's delete port, freeing the slot.
- Acts as the deleting agent paired with the inserting side, using a timestamped FIFO of outstanding locations.

Parameters:
- LOC_WIDTH, 6, width of a solver queue location.
- QUEUE_LEN, 64, max outstanding locations tracked; equals solver QUEUE_LEN.
- HOLD_CYCLES, 16, cycles a location stays occupied before release; must be >= 1.
- TS_WIDTH, 8, timestamp counter width; requires HOLD_CYCLES + QUEUE_LEN < 2^TS_WIDTH.

Ports:
- clk, input, 1, system clock; all state updates on rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- valid_in, input, 1, solver result valid (solver valid_out).
- insert_success, input, 1, solver insert succeeded; meaningful only when valid_in=1.
- insert_loc, input, LOC_WIDTH, location granted by solver.
- flush, input, 1, release pending locations immediately, ignoring age.
- valid_delete, output, 1, registered one-cycle delete strobe to solver.
- del_loc_out, output, LOC_WIDTH, location to delete (drives solver del_loc_in).
- pending_cnt, output, LOC_WIDTH+1, number of outstanding entries.
- empty, output, 1, pending_cnt == 0.
- overflow, output, 1, sticky: a push was dropped because the FIFO was full.

Behaviour:
- Reset (async, rst_n=0): valid_delete=0, del_loc_out=0, pending_cnt=0, empty=1, overflow=0, timestamp counter now=0, FIFO pointers=0. Reset mid-operation discards all entries; no deletes are issued for them.
- Timestamp: now increments by 1 every cycle (mod 2^TS_WIDTH) while out of reset.
- Push: at an edge where valid_in=1 and insert_success=1, append {insert_loc, ts=now}. valid_in=1 with insert_success=0 is ignored.
- Age: age = (now - head.ts) mod 2^TS_WIDTH, computed in TS_WIDTH bits.
- Pop condition, evaluated each cycle: !empty && (flush || age >= HOLD_CYCLES).
- Pop rate: at most one pop per cycle, always from the head (FIFO order = expiry order, since every entry has the same hold).
- Pop output: on the pop edge, valid_delete<=1 and del_loc_out<=head.loc. On any edge with no pop, valid_delete<=0 and del_loc_out holds its previous value.
- Latency: valid_delete for an entry is first high exactly HOLD_CYCLES edges after its push edge, unless delayed behind older entries (one pop per cycle) or advanced by flush.
- Simultaneous push and pop: both performed; pending_cnt unchanged.
- Full (pending_cnt == QUEUE_LEN):
  - push with no pop in the same cycle: entry dropped, overflow<=1 (sticky until reset);
  - push with a pop in the same cycle: push accepted.
- Pointer wrap: pointers of width log2(QUEUE_LEN) wrap modulo QUEUE_LEN; full/empty are derived from pending_cnt.
- Empty: no pop and valid_delete=0, even when flush=1.
- Flush: pops one entry per cycle while asserted. Pushes in the same cycles are still accepted, and an entry pushed during flush may be popped on a later flush cycle.
- Duplicate locations are not checked; the solver guarantees unique live locations.
- pending_cnt, empty and overflow are registered and reflect state after the current edge.

Test Plan:
- Reset hold: rst_n=0 for 5 cycles with valid_in toggling -> valid_delete=0, pending_cnt=0, empty=1 throughout. Release reset -> same until a push.
- Single release: one push of loc=5 at edge E, HOLD_CYCLES=16 -> valid_delete=1 and del_loc_out=5 only in the cycle after edge E+16; pending_cnt goes 1 -> 0.
- Failed insert ignored: valid_in=1, insert_success=0, loc=9 -> pending_cnt stays 0, no delete ever issued.
- Back-to-back: push locs 0..5 on 6 consecutive edges -> deletes 0..5 on 6 consecutive cycles, each 16 cycles after its push. Overlap one new push with the first pop -> pending_cnt unchanged on that edge.
- Full/overflow: QUEUE_LEN=4, HOLD=16, push 5 locs on consecutive edges -> 5th dropped, overflow=1, pending_cnt=4, only 4 deletes issued. Repeat with the 5th push coinciding with a pop -> accepted, overflow=0.
- Flush and wrap: TS_WIDTH=5, HOLD=16, run 100 cycles of random pushes -> every delete occurs at age exactly 16 (or later only when queued behind older entries). Assert flush with 3 pending -> 3 deletes on 3 consecutive cycles, then empty=1. Reset mid-stream -> no further deletes.
